// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display bus; load/value_in/blank_lz/blink_en/dec_seg into the scanner, dec_bcd/seg/an out of it
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic [3:0]  dec_bcd;
  logic [7:0]  dec_seg;
  logic [7:0]  seg;
  logic [3:0]  an;
  modport master (output load, value_in, blank_lz, blink_en, dec_seg, input dec_bcd, seg, an);
  modport slave  (input load, value_in, blank_lz, blink_en, dec_seg, output dec_bcd, seg, an);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scanner (clk, rst, bus: load/value_in shadow update at frame end, blank_lz, blink_en, dec_bcd->dec_seg decoder loop, registered active-low seg/an)
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_shadow;
  logic          r_pending;
  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          w_tick;
  logic          w_frame_end;
  logic          w_frame_wrap;
  logic          w_lit;
  logic          w_z3;
  logic          w_z2;
  logic          w_z1;
  logic [3:0]    w_lz;
  assign w_tick       = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_frame_end  = w_tick && r_idx == 2'd3;
  assign w_frame_wrap = r_frame == FW'(BLINK_FRAMES - 1);
  assign w_z3         = r_disp[15:12] == 4'd0;
  assign w_z2         = r_disp[11:8] == 4'd0;
  assign w_z1         = r_disp[7:4] == 4'd0;
  assign w_lz         = {w_z3, w_z3 & w_z2, w_z3 & w_z2 & w_z1, 1'b0} & {4{bus.blank_lz}};
  assign w_lit        = !(w_lz[r_idx] || (r_phase && bus.blink_en[r_idx]));
  assign bus.dec_bcd  = r_disp[{r_idx, 2'b00} +: 4];
  assign bus.seg      = r_seg;
  assign bus.an       = r_an;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_disp    <= 16'h0000;
      r_shadow  <= 16'h0000;
      r_pending <= 1'b0;
      r_frame   <= '0;
      r_phase   <= 1'b0;
      r_seg     <= 8'hFF;
      r_an      <= 4'b1111;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_frame_end) begin
        r_frame <= w_frame_wrap ? '0 : r_frame + FW'(1);
        if (w_frame_wrap) r_phase <= ~r_phase;
        if (r_pending) begin
          r_disp    <= r_shadow;
          r_pending <= 1'b0;
        end
      end
      if (bus.load) begin
        r_shadow  <= bus.value_in;
        r_pending <= 1'b1;
      end
      r_seg <= w_lit ? bus.dec_seg : 8'hFF;
      r_an  <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
    end
  end
endmodule
